// File: rtl/cd_ctree_scan_if.sv
// rtl/cd_ctree_scan_if.sv - dual-rail channel, scan and status bundle for cd_ctree_scan
interface cd_ctree_scan_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]  DT;
  logic [N_CH-1:0]  DF;
  logic             SE;
  logic             SI;
  logic             SO;
  logic             DONE;
  logic             ILLEGAL;
  logic [CNT_W-1:0] TOKENS;

  modport master (
    output DT, DF, SE, SI,
    input  SO, DONE, ILLEGAL, TOKENS
  );

  modport slave (
    input  DT, DF, SE, SI,
    output SO, DONE, ILLEGAL, TOKENS
  );
endinterface

// File: rtl/cd_ctree_scan.sv
// rtl/cd_ctree_scan.sv - two-level C-element completion tree with scan chain and token/illegal tracking
module cd_ctree_scan #(
  parameter int N_CH  = 8,
  parameter int GRP   = 4,
  parameter int CNT_W = 8
) (
  input  logic         CK,
  input  logic         RST,
  cd_ctree_scan_if.slave bus
);
  localparam int NG = N_CH / GRP;

  logic [N_CH-1:0]  valid;
  logic [NG-1:0]    g_q;
  logic [NG-1:0]    g_d;
  logic             done_q;
  logic             done_d;
  logic             illegal_q;
  logic [CNT_W-1:0] tokens_q;
  logic             token_inc;
  logic             any_illegal;

  // both-rails-high still counts as valid for completion
  assign valid       = bus.DT | bus.DF;
  assign any_illegal = |(bus.DT & bus.DF);

  // next C-element state: scan shift, or group/top Muller rules (top sees current group regs)
  always_comb begin
    g_d    = g_q;
    done_d = done_q;
    if (bus.SE) begin
      g_d[0] = bus.SI;
      for (int g = 1; g < NG; g++) begin
        g_d[g] = g_q[g-1];
      end
      done_d = g_q[NG-1];
    end else begin
      for (int g = 0; g < NG; g++) begin
        if (&valid[g*GRP +: GRP]) begin
          g_d[g] = 1'b1;
        end else if (~|valid[g*GRP +: GRP]) begin
          g_d[g] = 1'b0;
        end
      end
      if (&g_q) begin
        done_d = 1'b1;
      end else if (~|g_q) begin
        done_d = 1'b0;
      end
    end
  end

  // a shifted-in rising DONE is not a completed token
  assign token_inc = !bus.SE && !done_q && done_d;

  // state registers; reset overrides scan and data
  always_ff @(posedge CK) begin
    if (RST) begin
      g_q       <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      tokens_q  <= '0;
    end else begin
      g_q    <= g_d;
      done_q <= done_d;
      if (!bus.SE && any_illegal) begin
        illegal_q <= 1'b1;
      end
      if (token_inc && (tokens_q != {CNT_W{1'b1}})) begin
        tokens_q <= tokens_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.SO      = done_q;
  assign bus.DONE    = done_q;
  assign bus.ILLEGAL = illegal_q;
  assign bus.TOKENS  = tokens_q;
endmodule
